// File: rtl/if_id_fetch_buffer_pkg.sv
// if_id_fetch_buffer_pkg: shared constants, entry type and AdEL address check for the IF/ID fetch buffer
package if_id_fetch_buffer_pkg;
  localparam logic [31:0] INS_NOP = 32'h0000_0000;
  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [31:0] PC_TEXT_BASE = 32'h0000_3000;
  localparam logic [31:0] PC_TEXT_LAST = 32'h0000_6FFC;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
    logic [4:0] exc;
  } entry_t;
  function automatic logic is_adel(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || (pc < PC_TEXT_BASE) || (pc > PC_TEXT_LAST);
  endfunction
endpackage

// File: rtl/if_id_fetch_buffer_if.sv
// if_id_fetch_buffer_if: fetch/decode handshake bundle; master = pipeline side, slave = buffer
interface if_id_fetch_buffer_if #(parameter int DEPTH = 2);
  localparam int PTR_W = $clog2(DEPTH);
  logic in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_ins;
  logic in_ready;
  logic out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_ins;
  logic [4:0] out_exc;
  logic out_ready;
  logic flush;
  logic [PTR_W:0] count;
  modport master(
    output in_valid, in_pc, in_ins, out_ready, flush,
    input in_ready, out_valid, out_pc, out_ins, out_exc, count
  );
  modport slave(
    input in_valid, in_pc, in_ins, out_ready, flush,
    output in_ready, out_valid, out_pc, out_ins, out_exc, count
  );
endinterface

// File: rtl/if_id_fetch_buffer_ptr_ctrl.sv
// fifo_ptr_ctrl: read/write pointers, occupancy and push/pop/flush arbitration (in: clk, rst, i_valid, i_ready, i_flush; out: o_push, o_in_ready, o_out_valid, o_rd_ptr, o_wr_ptr, o_count)
module fifo_ptr_ctrl #(
  parameter int DEPTH = 2
) (
  input logic clk,
  input logic rst,
  input logic i_valid,
  input logic i_ready,
  input logic i_flush,
  output logic o_push,
  output logic o_in_ready,
  output logic o_out_valid,
  output logic [$clog2(DEPTH)-1:0] o_rd_ptr,
  output logic [$clog2(DEPTH)-1:0] o_wr_ptr,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);
  logic [PTR_W-1:0] r_rd_ptr, r_wr_ptr;
  logic [PTR_W:0] r_count;
  logic w_pop;
  assign o_in_ready = r_count != FULL;
  assign o_out_valid = r_count != '0;
  assign o_push = i_valid && o_in_ready && !i_flush;
  assign w_pop = o_out_valid && i_ready && !i_flush;
  assign o_rd_ptr = r_rd_ptr;
  assign o_wr_ptr = r_wr_ptr;
  assign o_count = r_count;
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count <= '0;
    end else begin
      if (o_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (o_push != w_pop) r_count <= o_push ? r_count + 1'b1 : r_count - 1'b1;
    end
  end
endmodule

// File: rtl/if_id_fetch_buffer.sv
// if_id_fetch_buffer: IF->ID in-order FIFO (clk, rst, bus = if_id_fetch_buffer_if.slave); define IF_ADEL_EN to tag misaligned/out-of-text PCs with AdEL
module if_id_fetch_buffer
  import if_id_fetch_buffer_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input logic clk,
  input logic rst,
  if_id_fetch_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  logic w_push;
  logic [PTR_W-1:0] w_rd_ptr, w_wr_ptr;
  entry_t w_in, w_head;
  fifo_ptr_ctrl #(.DEPTH(DEPTH)) u_ctrl (
    .clk(clk),
    .rst(rst),
    .i_valid(bus.in_valid),
    .i_ready(bus.out_ready),
    .i_flush(bus.flush),
    .o_push(w_push),
    .o_in_ready(bus.in_ready),
    .o_out_valid(bus.out_valid),
    .o_rd_ptr(w_rd_ptr),
    .o_wr_ptr(w_wr_ptr),
    .o_count(bus.count)
  );
`ifdef IF_ADEL_EN
  logic w_adel;
  entry_t r_mem [DEPTH];
  always_comb begin
    w_adel = is_adel(bus.in_pc);
    w_in = '{pc: bus.in_pc, ins: w_adel ? INS_NOP : bus.in_ins, exc: w_adel ? EXC_ADEL : EXC_NONE};
  end
  always_ff @(posedge clk) if (w_push) r_mem[w_wr_ptr] <= w_in;
  assign w_head = r_mem[w_rd_ptr];
`else
  logic [31:0] r_pc [DEPTH];
  logic [31:0] r_ins [DEPTH];
  assign w_in = '{pc: bus.in_pc, ins: bus.in_ins, exc: EXC_NONE};
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc[w_wr_ptr] <= w_in.pc;
      r_ins[w_wr_ptr] <= w_in.ins;
    end
  end
  assign w_head = '{pc: r_pc[w_rd_ptr], ins: r_ins[w_rd_ptr], exc: EXC_NONE};
`endif
  // an empty buffer presents a NOP bubble so decode never sees stale storage
  assign bus.out_pc = bus.out_valid ? w_head.pc : 32'h0;
  assign bus.out_ins = bus.out_valid ? w_head.ins : INS_NOP;
  assign bus.out_exc = bus.out_valid ? w_head.exc : EXC_NONE;
endmodule

// File: tb/tb_if_id_fetch_buffer.sv
// tb_if_id_fetch_buffer: directed self-checking bench for if_id_fetch_buffer with DEPTH=2
module tb_if_id_fetch_buffer;
  logic clk = 0;
  logic rst;
  int n_vec = 0;
  int n_err = 0;
  if_id_fetch_buffer_if #(.DEPTH(2)) bus ();
  if_id_fetch_buffer #(.DEPTH(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins, input logic rdy, input logic fl);
    bus.in_valid = v;
    bus.in_pc = pc;
    bus.in_ins = ins;
    bus.out_ready = rdy;
    bus.flush = fl;
  endtask
  task automatic test_reset();
    rst = 1;
    drive(0, 32'h0, 32'h0, 0, 0);
    step();
    step();
    rst = 0;
    n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    n_vec++; if (bus.out_ins !== 32'h0) begin n_err++; $display("FAIL reset_out_ins got %h want 0", bus.out_ins); end
    n_vec++; if (bus.out_pc !== 32'h0) begin n_err++; $display("FAIL reset_out_pc got %h want 0", bus.out_pc); end
    n_vec++; if (bus.count !== 2'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", bus.count); end
    n_vec++; if (bus.out_exc !== 5'd0) begin n_err++; $display("FAIL reset_out_exc got %0d want 0", bus.out_exc); end
  endtask
  task automatic test_streaming();
    logic [31:0] pcs [3] = '{32'h3000, 32'h3004, 32'h3008};
    for (int i = 0; i < 3; i++) begin
      drive(1, pcs[i], 32'h2000_0000 + 32'(i), 1, 0);
      step();
      n_vec++; if (bus.out_pc !== pcs[i]) begin n_err++; $display("FAIL stream_pc%0d got %h want %h", i, bus.out_pc, pcs[i]); end
      n_vec++; if (bus.out_ins !== 32'h2000_0000 + 32'(i)) begin n_err++; $display("FAIL stream_ins%0d got %h want %h", i, bus.out_ins, 32'h2000_0000 + 32'(i)); end
      n_vec++; if (bus.count !== 2'd1) begin n_err++; $display("FAIL stream_count%0d got %0d want 1", i, bus.count); end
    end
    drive(0, 32'h0, 32'h0, 1, 0);
    step();
    n_vec++; if (bus.out_valid !== 1'b0 || bus.count !== 2'd0) begin n_err++; $display("FAIL stream_drain got valid=%b count=%0d want 0/0", bus.out_valid, bus.count); end
  endtask
  task automatic test_fill();
    drive(1, 32'h3000, 32'hA, 0, 0);
    step();
    drive(1, 32'h3004, 32'hB, 0, 0);
    step();
    n_vec++; if (bus.count !== 2'd2) begin n_err++; $display("FAIL fill_count got %0d want 2", bus.count); end
    n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL fill_in_ready got %b want 0", bus.in_ready); end
    drive(1, 32'h3008, 32'hC, 0, 0);
    step();
    n_vec++; if (bus.count !== 2'd2 || bus.out_pc !== 32'h3000) begin n_err++; $display("FAIL fill_ignored got count=%0d pc=%h want 2/3000", bus.count, bus.out_pc); end
    drive(0, 32'h0, 32'h0, 1, 0);
    step();
    n_vec++; if (bus.out_pc !== 32'h3004 || bus.count !== 2'd1) begin n_err++; $display("FAIL fill_pop1 got pc=%h count=%0d want 3004/1", bus.out_pc, bus.count); end
    step();
    n_vec++; if (bus.count !== 2'd0 || bus.out_valid !== 1'b0 || bus.out_pc !== 32'h0) begin n_err++; $display("FAIL fill_pop2 got count=%0d valid=%b pc=%h want 0/0/0", bus.count, bus.out_valid, bus.out_pc); end
  endtask
  task automatic test_back_to_back();
    drive(1, 32'h3020, 32'h11, 0, 0);
    step();
    drive(1, 32'h3024, 32'h22, 1, 0);
    step();
    n_vec++; if (bus.count !== 2'd1 || bus.out_pc !== 32'h3024) begin n_err++; $display("FAIL b2b_head got count=%0d pc=%h want 1/3024", bus.count, bus.out_pc); end
    n_vec++; if (bus.out_ins !== 32'h22) begin n_err++; $display("FAIL b2b_ins got %h want 22", bus.out_ins); end
    drive(0, 32'h0, 32'h0, 1, 0);
    step();
    n_vec++; if (bus.count !== 2'd0) begin n_err++; $display("FAIL b2b_drain got %0d want 0", bus.count); end
  endtask
  task automatic test_flush();
    drive(1, 32'h3000, 32'h1, 0, 0);
    step();
    drive(1, 32'h3004, 32'h2, 0, 0);
    step();
    drive(1, 32'h3010, 32'h3, 0, 1);
    step();
    n_vec++; if (bus.count !== 2'd0 || bus.out_valid !== 1'b0) begin n_err++; $display("FAIL flush_full got count=%0d valid=%b want 0/0", bus.count, bus.out_valid); end
    drive(0, 32'h0, 32'h0, 1, 0);
    step();
    n_vec++; if (bus.count !== 2'd0 || bus.out_pc !== 32'h0) begin n_err++; $display("FAIL flush_no3010 got count=%0d pc=%h want 0/0", bus.count, bus.out_pc); end
    drive(1, 32'h3030, 32'h4, 0, 0);
    step();
    n_vec++; if (bus.out_pc !== 32'h3030 || bus.count !== 2'd1) begin n_err++; $display("FAIL flush_refill got pc=%h count=%0d want 3030/1", bus.out_pc, bus.count); end
    drive(1, 32'h3040, 32'h5, 1, 1);
    step();
    n_vec++; if (bus.count !== 2'd0 || bus.out_valid !== 1'b0) begin n_err++; $display("FAIL flush_partial got count=%0d valid=%b want 0/0", bus.count, bus.out_valid); end
    drive(0, 32'h0, 32'h0, 1, 0);
    step();
    n_vec++; if (bus.count !== 2'd0) begin n_err++; $display("FAIL flush_no3040 got %0d want 0", bus.count); end
  endtask
  task automatic test_rst_flush();
    drive(1, 32'h3050, 32'h6, 0, 0);
    step();
    rst = 1;
    drive(1, 32'h3054, 32'h7, 1, 1);
    step();
    rst = 0;
    drive(0, 32'h0, 32'h0, 0, 0);
    n_vec++; if (bus.count !== 2'd0 || bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_flush got count=%0d ready=%b want 0/1", bus.count, bus.in_ready); end
  endtask
  task automatic test_adel();
`ifdef IF_ADEL_EN
    logic [31:0] pcs [5] = '{32'h3002, 32'h7000, 32'h3004, 32'h2FFC, 32'h6FFC};
    logic [4:0] exc [5] = '{5'd4, 5'd4, 5'd0, 5'd4, 5'd0};
`else
    logic [31:0] pcs [5] = '{32'h3002, 32'h7000, 32'h3004, 32'h2FFC, 32'h6FFC};
    logic [4:0] exc [5] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
`endif
    for (int i = 0; i < 5; i++) begin
      logic [31:0] w_ins;
      w_ins = (exc[i] != 5'd0) ? 32'h0 : 32'hCAFE_0000 + 32'(i);
      drive(1, pcs[i], 32'hCAFE_0000 + 32'(i), 1, 0);
      step();
      n_vec++; if (bus.out_exc !== exc[i]) begin n_err++; $display("FAIL adel_exc%0d got %0d want %0d", i, bus.out_exc, exc[i]); end
      n_vec++; if (bus.out_ins !== w_ins || bus.out_pc !== pcs[i]) begin n_err++; $display("FAIL adel_entry%0d got pc=%h ins=%h want %h/%h", i, bus.out_pc, bus.out_ins, pcs[i], w_ins); end
    end
    drive(0, 32'h0, 32'h0, 1, 0);
    step();
    n_vec++; if (bus.out_exc !== 5'd0 || bus.out_valid !== 1'b0) begin n_err++; $display("FAIL adel_drain got exc=%0d valid=%b want 0/0", bus.out_exc, bus.out_valid); end
  endtask
  initial begin
    test_reset();
    test_streaming();
    test_fill();
    test_back_to_back();
    test_flush();
    test_rst_flush();
    test_adel();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
